// File: rtl/cpu_cs_wcs_banked.sv
// rtl/cpu_cs_wcs_banked.sv - banked writable control store with lane-serial loader
// Fetch reads one word per cycle; the loader gathers LANES lanes and commits a whole word at once.
module cpu_cs_wcs_banked #(
  parameter int DATA_W = 64,
  parameter int LANE_W = 16,
  parameter int ADDR_W = 12,
  parameter int NBANK  = 2,
  localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic              sysclk,
  input  logic              sys_rst_n,
  input  logic              fetch_valid,
  input  logic [BANK_W-1:0] fetch_bank,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] csbits_out,
  output logic              csbits_valid,
  input  logic              load_start,
  input  logic [BANK_W-1:0] load_bank,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              load_valid,
  input  logic [LANE_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              load_abort,
  output logic              load_busy,
  output logic [ADDR_W:0]   words_written
);

  localparam int LANES   = DATA_W / LANE_W;
  localparam int LANE_CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DEPTH   = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  state_t              state, state_nxt;
  logic [LANE_CW-1:0]  lane_cnt;
  logic [BANK_W-1:0]   ld_bank;
  logic [ADDR_W-1:0]   ld_addr;
  logic                ld_last;
  logic [LANE_W-1:0]   slots [LANES];
  logic [DATA_W-1:0]   word;
  logic                hshake, last_lane, stall, commit;
  logic                fetch_ok, load_ok;

  logic [DATA_W-1:0]   mem [NBANK][DEPTH];

  assign load_ready = (state == COLLECT);
  assign load_busy  = (state != IDLE);
  assign fetch_ok   = int'(fetch_bank) < NBANK;
  assign load_ok    = int'(ld_bank) < NBANK;

  always_comb begin
    hshake    = (state == COLLECT) && load_valid && !load_abort;
    last_lane = (lane_cnt == LANE_CW'(LANES - 1));
    // A fetch to the bank being loaded wins; the commit waits for a free cycle.
    stall     = fetch_valid && (fetch_bank == ld_bank);
    commit    = (state == WRITE) && !stall && !load_abort;
    state_nxt = state;
    case (state)
      IDLE:    if (load_start) state_nxt = COLLECT;
      COLLECT: if (hshake && last_lane) state_nxt = WRITE;
      WRITE:   if (commit) state_nxt = ld_last ? IDLE : COLLECT;
      default: state_nxt = IDLE;
    endcase
    if (load_abort) state_nxt = IDLE;
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < LANES; i++) word[i*LANE_W +: LANE_W] = slots[i];
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      lane_cnt      <= '0;
      ld_bank       <= '0;
      ld_addr       <= '0;
      ld_last       <= 1'b0;
      words_written <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && load_start && !load_abort) begin
        ld_bank  <= load_bank;
        ld_addr  <= load_addr;
        lane_cnt <= '0;
      end
      if (hshake) begin
        lane_cnt <= lane_cnt + 1'b1;
        if (last_lane) ld_last <= load_last;
      end
      if (commit) begin
        ld_addr  <= ld_addr + 1'b1;
        lane_cnt <= '0;
        if (words_written != '1) words_written <= words_written + 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csbits_out   <= '0;
      csbits_valid <= 1'b0;
    end else begin
      csbits_valid <= fetch_valid;
      if (fetch_valid) csbits_out <= fetch_ok ? mem[fetch_bank][fetch_addr] : '0;
    end
  end

  // Lane slots and storage carry no reset: contents survive reset by design.
  always_ff @(posedge sysclk) begin
    if (hshake) slots[lane_cnt] <= load_data;
  end

  always_ff @(posedge sysclk) begin
    if (commit && load_ok) mem[ld_bank][ld_addr] <= word;
  end

endmodule
